// File: rtl/ex_mem_skid_pkg.sv
// Shared definitions for the EX/MEM skid buffer: default widths and the buffer state encoding.
package ex_mem_skid_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RD_W_DEF = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ex_mem_entry_reg.sv
// Load-enabled holding register for one EX/MEM entry {result, ovf, rd, reg_wr}.
module ex_mem_entry_reg
    import ex_mem_skid_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            load,
    input  logic [XLEN-1:0] next_result,
    input  logic            next_ovf,
    input  logic [RD_W-1:0] next_rd,
    input  logic            next_reg_wr,
    output logic [XLEN-1:0] result,
    output logic            ovf,
    output logic [RD_W-1:0] rd,
    output logic            reg_wr
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            result <= '0;
            ovf    <= 1'b0;
            rd     <= '0;
            reg_wr <= 1'b0;
        end else if (load) begin
            result <= next_result;
            ovf    <= next_ovf;
            rd     <= next_rd;
            reg_wr <= next_reg_wr;
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// Two-entry in-order skid buffer between EX and MEM; fully registered handshake.
// Optional sticky overflow flag (ovf_sticky / ovf_clr) when OVF_STICKY_EN is defined.
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RD_W = RD_W_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] Result,
    input  logic            overflow,
    input  logic [RD_W-1:0] Rd,
    input  logic            Reg_Wr,
    input  logic            Flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_ovf,
    output logic [RD_W-1:0] out_rd,
`ifdef OVF_STICKY_EN
    output logic            ovf_sticky,
    input  logic            ovf_clr,
`endif
    output logic            out_reg_wr
);

    skid_state_t state;
    logic        valid_q;
    logic        ready_q;
    logic        accept;
    logic        deliver;
    logic        main_load;
    logic        skid_load;
    logic        from_skid;

    logic [XLEN-1:0] skid_result, main_next_result;
    logic            skid_ovf, main_next_ovf;
    logic [RD_W-1:0] skid_rd, main_next_rd;
    logic            skid_reg_wr, main_next_reg_wr;
    logic            main_reg_wr;

    // A flushed cycle never accepts; a delivery in that cycle still completes downstream.
    assign accept    = in_valid & ready_q & ~Flush;
    assign deliver   = valid_q & out_ready;
    assign from_skid = (state == TWO);
    assign skid_load = (state == ONE) & accept & ~deliver;
    assign main_load = (accept & ((state == EMPTY) | deliver))
                     | (from_skid & deliver & ~Flush);

    assign main_next_result = from_skid ? skid_result : Result;
    assign main_next_ovf    = from_skid ? skid_ovf    : overflow;
    assign main_next_rd     = from_skid ? skid_rd     : Rd;
    assign main_next_reg_wr = from_skid ? skid_reg_wr : Reg_Wr;

    ex_mem_entry_reg #(.XLEN(XLEN), .RD_W(RD_W)) u_main (
        .CLK         (CLK),
        .RST         (RST),
        .load        (main_load),
        .next_result (main_next_result),
        .next_ovf    (main_next_ovf),
        .next_rd     (main_next_rd),
        .next_reg_wr (main_next_reg_wr),
        .result      (out_result),
        .ovf         (out_ovf),
        .rd          (out_rd),
        .reg_wr      (main_reg_wr)
    );

    ex_mem_entry_reg #(.XLEN(XLEN), .RD_W(RD_W)) u_skid (
        .CLK         (CLK),
        .RST         (RST),
        .load        (skid_load),
        .next_result (Result),
        .next_ovf    (overflow),
        .next_rd     (Rd),
        .next_reg_wr (Reg_Wr),
        .result      (skid_result),
        .ovf         (skid_ovf),
        .rd          (skid_rd),
        .reg_wr      (skid_reg_wr)
    );

    always_ff @(posedge CLK) begin
        if (RST || Flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state   <= ONE;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                end
                ONE: if (accept && !deliver) begin
                    state   <= TWO;
                    valid_q <= 1'b1;
                    ready_q <= 1'b0;
                end else if (!accept && deliver) begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
                TWO: if (deliver) begin
                    state   <= ONE;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign in_ready   = ready_q;
    // Stale main contents must never look like a writeback.
    assign out_reg_wr = valid_q & main_reg_wr;

`ifdef OVF_STICKY_EN
    always_ff @(posedge CLK) begin
        if (RST)
            ovf_sticky <= 1'b0;
        else if (deliver && out_ovf)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end
`endif

endmodule
